// File: rtl/sccb_cmd_arbiter_if.sv
// Command bus between the SCCB command arbiter and its neighbours:
// the init sequencer (cfg_*), runtime command writers (usr_*) and the
// SCCB byte sender (snd_*). The arbiter connects through the slave
// modport; the surrounding logic (or a bench) uses the master modport.
interface sccb_cmd_arbiter_if;
  logic        cfg_valid;
  logic [15:0] cfg_cmd;
  logic        cfg_taken;
  logic        usr_wr;
  logic [15:0] usr_cmd;
  logic        usr_full;
  logic [4:0]  usr_count;
  logic        usr_ovf;
  logic        snd_send;
  logic [15:0] snd_cmd;
  logic        snd_taken;
  logic [1:0]  grant;
  logic        busy;

  modport master (
    output cfg_valid, cfg_cmd, usr_wr, usr_cmd, snd_taken,
    input  cfg_taken, usr_full, usr_count, usr_ovf, snd_send, snd_cmd,
           grant, busy
  );

  modport slave (
    input  cfg_valid, cfg_cmd, usr_wr, usr_cmd, snd_taken,
    output cfg_taken, usr_full, usr_count, usr_ovf, snd_send, snd_cmd,
           grant, busy
  );
endinterface

// File: rtl/sccb_cmd_arbiter.sv
// SCCB command arbiter: picks the next 16-bit register command for the
// SCCB sender, giving the init sequencer (cfg) fixed priority over the
// runtime command FIFO (usr). Each command is held on snd_cmd with
// snd_send high until the sender acknowledges it with snd_taken.
// Optional feature: define SCCB_ARB_GAP_EN to insert GAP_CYCLES+1 idle
// cycles after every accepted command (GAP state and down-counter).
// Without the macro GAP_CYCLES has no effect.
module sccb_cmd_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2500
) (
  input  logic              clk,
  input  logic              rst_n,
  sccb_cmd_arbiter_if.slave bus
);

  localparam int         AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C    = 5'(FIFO_DEPTH);
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CFG  = 2'b01;
  localparam logic [1:0] GRANT_USR  = 2'b10;

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sccb_cmd_arbiter: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("sccb_cmd_arbiter: GAP_CYCLES must not be negative");
  end

`ifdef SCCB_ARB_GAP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_t;
`endif

  state_t        state;
  logic          snd_send_q;
  logic [15:0]   snd_cmd_q;
  logic [1:0]    grant_q;
  logic          cfg_taken_q;
  logic          busy_q;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          ovf;

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          pop;

  // Fullness is judged on the current occupancy, so a write in the same
  // cycle as a pop from a full FIFO is still dropped.
  assign full  = (count == DEPTH_C);
  assign empty = (count == 5'd0);
  assign wr_en = bus.usr_wr && !full;
  assign pop   = (state == SEND) && bus.snd_taken && (grant_q == GRANT_USR);

  // Command storage: data only, no reset needed (occupancy guards reads).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.usr_cmd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag: set by any write attempted while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (bus.usr_wr && full) begin
      ovf <= 1'b1;
    end
  end

  // Arbitration FSM with registered sender handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      snd_send_q  <= 1'b0;
      snd_cmd_q   <= 16'h0000;
      grant_q     <= GRANT_NONE;
      cfg_taken_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SCCB_ARB_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      cfg_taken_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            snd_cmd_q  <= bus.cfg_cmd;
            grant_q    <= GRANT_CFG;
            snd_send_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= SEND;
          end else if (!empty) begin
            snd_cmd_q  <= mem[rd_ptr];
            grant_q    <= GRANT_USR;
            snd_send_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          // The latched command always completes, even if cfg_valid drops.
          if (bus.snd_taken) begin
            snd_send_q <= 1'b0;
            if (grant_q == GRANT_CFG) begin
              cfg_taken_q <= 1'b1;
            end
`ifdef SCCB_ARB_GAP_EN
            gap_cnt <= GW'(GAP_CYCLES);
            state   <= GAP;
`else
            grant_q <= GRANT_NONE;
            busy_q  <= 1'b0;
            state   <= IDLE;
`endif
          end
        end
`ifdef SCCB_ARB_GAP_EN
        GAP: begin
          // Count down to zero, then one more cycle before returning to IDLE.
          if (gap_cnt == '0) begin
            grant_q <= GRANT_NONE;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
`endif
        default: begin
          snd_send_q <= 1'b0;
          grant_q    <= GRANT_NONE;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.snd_send  = snd_send_q;
  assign bus.snd_cmd   = snd_cmd_q;
  assign bus.grant     = grant_q;
  assign bus.cfg_taken = cfg_taken_q;
  assign bus.busy      = busy_q;
  assign bus.usr_full  = full;
  assign bus.usr_count = count;
  assign bus.usr_ovf   = ovf;

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Bench for sccb_cmd_arbiter. Stimulus pushes each command it expects to
// see on the sender side into a queue; a monitor pops and compares on
// every rising snd_send. A simple sender model answers with snd_taken.
module tb_sccb_cmd_arbiter;
  localparam int DEPTH = 4;
  localparam int GAP   = 10;

  typedef struct packed {
    logic [1:0]  g;
    logic [15:0] c;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int   errors     = 0;
  int   checks     = 0;
  int   cyc        = 0;
  int   take_cyc   = -100;
  int   last_gap   = -1;
  int   cfg_pulses = 0;
  logic sender_en  = 1'b0;
  int   taken_delay = 3;
  exp_t exp_q[$];

  sccb_cmd_arbiter_if bus();

  sccb_cmd_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge index bookkeeping: take_cyc is the index of the edge sampling snd_taken.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.snd_taken) take_cyc <= cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sender model: acknowledges snd_send after taken_delay cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.snd_taken = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.snd_taken) begin
        bus.snd_taken = 1'b0;
      end else if (sender_en && bus.snd_send === 1'b1) begin
        if (wait_cnt >= taken_delay) begin
          bus.snd_taken = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compare every new send against the scoreboard.
  initial begin
    logic prev_send;
    exp_t e;
    prev_send = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cfg_taken === 1'b1) cfg_pulses++;
      if (bus.snd_send === 1'b1 && !prev_send) begin
        last_gap = cyc - 1 - take_cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send: got cmd=%h grant=%b, expected no send",
                   bus.snd_cmd, bus.grant);
        end else begin
          e = exp_q.pop_front();
          check("send_cmd_grant", {14'd0, bus.grant, bus.snd_cmd}, {14'd0, e.g, e.c});
        end
      end
      prev_send = (bus.snd_send === 1'b1);
    end
  end

  task automatic set_sender(input logic en, input int d);
    @(posedge clk);
    #1;
    sender_en   = en;
    taken_delay = d;
    @(negedge clk);
  endtask

  task automatic wait_cfg_taken(input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (bus.cfg_taken === 1'b1) seen = 1;
    end
    check({name, "_cfg_taken_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.usr_count === 5'd0) idle = 1;
    end
    check({name, "_idle_reached"}, 32'(idle), 32'd1);
  endtask

  task automatic check_zero(input string p);
    check({p, "_snd_send"},  32'(bus.snd_send),  32'd0);
    check({p, "_snd_cmd"},   32'(bus.snd_cmd),   32'd0);
    check({p, "_cfg_taken"}, 32'(bus.cfg_taken), 32'd0);
    check({p, "_grant"},     32'(bus.grant),     32'd0);
    check({p, "_busy"},      32'(bus.busy),      32'd0);
    check({p, "_usr_full"},  32'(bus.usr_full),  32'd0);
    check({p, "_usr_count"}, 32'(bus.usr_count), 32'd0);
    check({p, "_usr_ovf"},   32'(bus.usr_ovf),   32'd0);
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_cmd   = 16'h0000;
    bus.usr_wr    = 1'b0;
    bus.usr_cmd   = 16'h0000;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    set_sender(1'b1, 3);

    // Single cfg command, 1-cycle latency, one cfg_taken pulse
    exp_q.push_back('{g: 2'b01, c: 16'h1280});
    bus.cfg_cmd   = 16'h1280;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    check("latency_snd_send", 32'(bus.snd_send), 32'd1);
    wait_cfg_taken("a");
    bus.cfg_valid = 1'b0;
    wait_idle("a");
    check("a_cfg_taken_pulses", 32'(cfg_pulses), 32'd1);

    // Simultaneous cfg and usr: cfg wins, usr follows
    exp_q.push_back('{g: 2'b01, c: 16'h1204});
    exp_q.push_back('{g: 2'b10, c: 16'h3A04});
    bus.usr_cmd   = 16'h3A04;
    bus.usr_wr    = 1'b1;
    bus.cfg_cmd   = 16'h1204;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.usr_wr = 1'b0;
    check("b_usr_count_1", 32'(bus.usr_count), 32'd1);
    wait_cfg_taken("b");
    bus.cfg_valid = 1'b0;
    wait_idle("b");
    check("b_usr_count_0", 32'(bus.usr_count), 32'd0);
    check("b_cfg_taken_pulses", 32'(cfg_pulses), 32'd2);

    // Five writes with no taken: full, count 4, overflow, 5th dropped
    set_sender(1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back('{g: 2'b10, c: 16'hC000 + 16'(i)});
      bus.usr_cmd = 16'hC000 + 16'(i);
      bus.usr_wr  = 1'b1;
      @(negedge clk);
    end
    bus.usr_wr = 1'b0;
    @(negedge clk);
    check("c_usr_full", 32'(bus.usr_full), 32'd1);
    check("c_usr_count", 32'(bus.usr_count), 32'd4);
    check("c_usr_ovf", 32'(bus.usr_ovf), 32'd1);
    set_sender(1'b1, 2);
    wait_idle("c");
    check("c_ovf_sticky", 32'(bus.usr_ovf), 32'd1);

    // Asynchronous reset in the middle of a usr send
    set_sender(1'b0, 2);
    exp_q.push_back('{g: 2'b10, c: 16'hD001});
    bus.usr_cmd = 16'hD001;
    bus.usr_wr  = 1'b1;
    @(negedge clk);
    bus.usr_cmd = 16'hD002;
    @(negedge clk);
    bus.usr_wr = 1'b0;
    @(negedge clk);
    check("r_grant_usr", 32'(bus.grant), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    set_sender(1'b1, 1);
    repeat (10) @(negedge clk);
    check("r_usr_count", 32'(bus.usr_count), 32'd0);
    check("r_busy", 32'(bus.busy), 32'd0);
    check("r_cfg_taken_pulses", 32'(cfg_pulses), 32'd2);

    // Write coincident with pop while full: write dropped, count 4 -> 3
    set_sender(1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{g: 2'b10, c: 16'hE001 + 16'(i)});
      bus.usr_cmd = 16'hE001 + 16'(i);
      bus.usr_wr  = 1'b1;
      @(negedge clk);
    end
    bus.usr_wr = 1'b0;
    @(negedge clk);
    check("d_usr_count_4", 32'(bus.usr_count), 32'd4);
    check("d_usr_ovf_clear", 32'(bus.usr_ovf), 32'd0);
    @(posedge clk);
    #1;
    sender_en   = 1'b1;
    taken_delay = 0;
    bus.usr_cmd = 16'hE005;
    bus.usr_wr  = 1'b1;
    @(posedge clk);
    #1;
    bus.usr_wr = 1'b0;
    sender_en  = 1'b0;
    @(negedge clk);
    check("d_usr_count_3", 32'(bus.usr_count), 32'd3);
    check("d_usr_ovf", 32'(bus.usr_ovf), 32'd1);
    check("d_usr_full", 32'(bus.usr_full), 32'd0);
    set_sender(1'b1, 1);
    wait_idle("d");

`ifdef SCCB_ARB_GAP_EN
    // Two back-to-back cfg commands separated by the gap
    set_sender(1'b1, 1);
    exp_q.push_back('{g: 2'b01, c: 16'h2001});
    exp_q.push_back('{g: 2'b01, c: 16'h2002});
    bus.cfg_cmd   = 16'h2001;
    bus.cfg_valid = 1'b1;
    wait_cfg_taken("g1");
    bus.cfg_cmd = 16'h2002;
    wait_cfg_taken("g2");
    bus.cfg_valid = 1'b0;
    wait_idle("g");
    check("g_gap_edges", 32'(last_gap), 32'd12);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
